ramsdp_arb: RTL and testbench

Round-robin arbiter and initialiser that shares one simple-dual-port RAM between N requesters. Each requester has a write channel and a read channel with valid/ready handshakes. Each cycle, one write is granted to the RAM write port and one read to the RAM read port, independently. After reset the block zero-fills the whole memory before accepting any traffic. It sits between the client blocks and the ramsdp macro it instantiates.

---
 rtl/ramsdp_arb_pkg.sv | 38 +++
 rtl/ramsdp.sv | 32 +++
 rtl/ramsdp_rrarb.sv | 56 +++++
 rtl/ramsdp_arb.sv | 161 ++++++++++++++++
 tb/tb_ramsdp_arb.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ramsdp_arb_pkg.sv
// Shared types and helpers for the RAM arbiter: FSM state encoding and the
// rotating-priority search used by both round-robin arbiters.
package ramsdp_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned RR_MAX = 16;

  // Returns {found, index} of the first set bit of valid starting at ptr, wrapping at n
  function automatic logic [4:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [3:0]        ptr,
                                         input logic [4:0]        n);
    logic       found;
    logic [3:0] pick;
    logic [4:0] idx;
    found = 1'b0;
    pick  = 4'd0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = 5'(ptr) + 5'(k);
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if ((5'(k) < n) && !found && (idx < n) && valid[idx[3:0]]) begin
        found = 1'b1;
        pick  = idx[3:0];
      end else begin
        found = found;
      end
    end
    return {found, pick};
  endfunction

endpackage

// File: rtl/ramsdp.sv
// Simple-dual-port RAM macro model: synchronous write on port A, registered
// read on port B; a same-cycle read of the written address returns old data.
module ramsdp #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_dout;

  // Storage array: write port A, registered read port B
  always_ff @(posedge clk) begin
    if (a_en && a_we) begin
      r_mem[a_addr] <= a_din;
    end
    if (b_en) begin
      r_dout <= r_mem[b_addr];
    end
  end

  assign b_dout = r_dout;

endmodule

// File: rtl/ramsdp_rrarb.sv
// Round-robin arbiter: combinational one-hot grant from valid and a rotating
// priority pointer that moves just past each granted requester.
module ramsdp_rrarb
  import ramsdp_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     w_ptr_nxt;
  logic [RR_MAX-1:0] w_valid16;
  logic [4:0]        w_pick;
  logic              w_found;
  logic [3:0]        w_idx;

  // Priority search over the zero-extended request vector
  always_comb begin
    w_valid16        = '0;
    w_valid16[N-1:0] = valid;
    w_pick           = rr_pick(w_valid16, 4'(r_ptr), 5'(N));
    w_found          = w_pick[4];
    w_idx            = w_pick[3:0];
  end

  // One-hot grant decode and pointer advance
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = w_found && (w_idx == 4'(i));
    end
    if (!w_found) begin
      w_ptr_nxt = r_ptr;
    end else if (w_idx == 4'(N - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = PW'(w_idx + 4'd1);
    end
  end

  // Priority pointer register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/ramsdp_arb.sv
// Shares one simple-dual-port RAM among N requesters: zero-fills the memory
// after reset, then arbitrates writes and reads independently each cycle.
module ramsdp_arb
  import ramsdp_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic            clk,
  input  logic            nreset,
  output logic            init_done,
  input  logic [N-1:0]    wr_valid,
  output logic [N-1:0]    wr_ready,
  input  logic [N*AW-1:0] wr_addr,
  input  logic [N*DW-1:0] wr_data,
  input  logic [N-1:0]    rd_valid,
  output logic [N-1:0]    rd_ready,
  input  logic [N*AW-1:0] rd_addr,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_data
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_init_cnt;
  logic          w_run;
  logic [N-1:0]  w_wr_req;
  logic [N-1:0]  w_rd_req;
  logic [N-1:0]  w_wr_gnt;
  logic [N-1:0]  w_rd_gnt;
  logic [AW-1:0] w_wr_addr_sel;
  logic [DW-1:0] w_wr_data_sel;
  logic [AW-1:0] w_rd_addr_sel;
  logic          w_a_we;
  logic [AW-1:0] w_a_addr;
  logic [DW-1:0] w_a_din;
  logic [DW-1:0] w_ram_dout;
  logic [N-1:0]  r_rsp_valid;

  // FSM state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: leave INIT on the edge that writes the last address
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == {AW{1'b1}}) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_run = 1'b0;
    case (r_state)
      ST_RUN:  w_run = 1'b1;
      ST_INIT: w_run = 1'b0;
      default: w_run = 1'b0;
    endcase
  end

  assign init_done = w_run;

  // Zero-fill address counter
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + AW'(1);
    end else begin
      r_init_cnt <= r_init_cnt;
    end
  end

  assign w_wr_req = wr_valid & {N{w_run}};
  assign w_rd_req = rd_valid & {N{w_run}};

  ramsdp_rrarb #(.N(N)) u_wr_arb (
    .clk    (clk),
    .nreset (nreset),
    .valid  (w_wr_req),
    .grant  (w_wr_gnt)
  );

  ramsdp_rrarb #(.N(N)) u_rd_arb (
    .clk    (clk),
    .nreset (nreset),
    .valid  (w_rd_req),
    .grant  (w_rd_gnt)
  );

  assign wr_ready = w_wr_gnt;
  assign rd_ready = w_rd_gnt;

  // Select the granted requester's address/data; port A belongs to zero-fill in INIT
  always_comb begin
    w_wr_addr_sel = '0;
    w_wr_data_sel = '0;
    w_rd_addr_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_wr_gnt[i]) begin
        w_wr_addr_sel = wr_addr[i*AW +: AW];
        w_wr_data_sel = wr_data[i*DW +: DW];
      end else begin
        w_wr_addr_sel = w_wr_addr_sel;
      end
      if (w_rd_gnt[i]) begin
        w_rd_addr_sel = rd_addr[i*AW +: AW];
      end else begin
        w_rd_addr_sel = w_rd_addr_sel;
      end
    end
    if (w_run) begin
      w_a_we   = |w_wr_gnt;
      w_a_addr = w_wr_addr_sel;
      w_a_din  = w_wr_data_sel;
    end else begin
      w_a_we   = 1'b1;
      w_a_addr = r_init_cnt;
      w_a_din  = '0;
    end
  end

  ramsdp #(.DW(DW), .AW(AW)) u_ram (
    .clk    (clk),
    .a_en   (w_a_we),
    .a_we   (w_a_we),
    .a_addr (w_a_addr),
    .a_din  (w_a_din),
    .b_en   (|w_rd_gnt),
    .b_addr (w_rd_addr_sel),
    .b_dout (w_ram_dout)
  );

  // Response strobe follows the read grant by one cycle
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rsp_valid <= '0;
    end else begin
      r_rsp_valid <= w_rd_gnt;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = (|r_rsp_valid) ? w_ram_dout : '0;

endmodule

// File: tb/tb_ramsdp_arb.sv
// Directed bench for ramsdp_arb: zero-fill timing, round-robin order,
// read/write collision, single requester, and reset during traffic.
module tb_ramsdp_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 6;

  logic            clk = 1'b0;
  logic            nreset;
  logic            init_done;
  logic [N-1:0]    wr_valid;
  logic [N-1:0]    wr_ready;
  logic [N*AW-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    rd_valid;
  logic [N-1:0]    rd_ready;
  logic [N*AW-1:0] rd_addr;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;

  int n_vec = 0;
  int n_err = 0;

  ramsdp_arb #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .init_done (init_done),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  // Release reset and count edges until init_done; valids stay as the caller left them
  task automatic run_init(input string tag);
    int   cnt;
    logic bad;
    cnt = 0;
    bad = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    while (cnt < 200) begin
      tick();
      cnt++;
      if (init_done) break;
      bad = bad | (|wr_ready) | (|rd_ready) | (|rsp_valid) | (|rsp_data);
    end
    wr_valid = '0;
    rd_valid = '0;
    check_vec({tag, "_cycles"}, 64'(cnt), 64'd64);
    check_vec({tag, "_quiet"}, 64'(bad), 64'd0);
  endtask

  logic [3:0] exp_rr [5];
  logic [3:0] exp_wr [4];

  initial begin
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_wr = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    nreset   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    wr_valid = 4'b1111;
    rd_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      set_wr(i, 6'd5, 32'hA5A5_0000 + 32'(i));
      set_rd(i, 6'(i));
    end
    #3;
    check_vec("rst_init_done", 64'(init_done), 64'd0);
    check_vec("rst_wr_ready", 64'(wr_ready), 64'd0);
    check_vec("rst_rd_ready", 64'(rd_ready), 64'd0);
    check_vec("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_vec("rst_rsp_data", 64'(rsp_data), 64'd0);
    #20;

    run_init("init1");
    check_vec("init1_done", 64'(init_done), 64'd1);

    // Every address reads back zero, including the one hammered during INIT
    for (int a = 0; a < 64; a++) begin
      set_rd(0, 6'(a));
      rd_valid = 4'b0001;
      #1;
      check_vec("zero_rd_ready", 64'(rd_ready), 64'b0001);
      tick();
      check_vec("zero_rsp_valid", 64'(rsp_valid), 64'b0001);
      check_vec("zero_rsp_data", 64'(rsp_data), 64'd0);
    end
    rd_valid = '0;

    // Lone requester 3: granted every cycle, pointer wraps back to 0
    set_rd(3, 6'd7);
    rd_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_vec("solo_rd_ready", 64'(rd_ready), 64'b1000);
      tick();
      check_vec("solo_rsp_valid", 64'(rsp_valid), 64'b1000);
    end
    rd_valid = '0;
    tick();
    check_vec("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    check_vec("idle_rsp_data", 64'(rsp_data), 64'd0);

    // Full contention on the read port
    for (int i = 0; i < N; i++) set_rd(i, 6'(20 + i));
    rd_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_vec("rr_rd_ready", 64'(rd_ready), 64'(exp_rr[k]));
      tick();
      check_vec("rr_rsp_valid", 64'(rsp_valid), 64'(exp_rr[k]));
    end
    rd_valid = '0;

    // Same-cycle write and read of addr 5 returns old data
    set_wr(2, 6'd5, 32'hDEAD_BEEF);
    wr_valid = 4'b0100;
    set_rd(1, 6'd5);
    rd_valid = 4'b0010;
    #1;
    check_vec("col_wr_ready", 64'(wr_ready), 64'b0100);
    check_vec("col_rd_ready", 64'(rd_ready), 64'b0010);
    tick();
    wr_valid = '0;
    check_vec("col_rsp_valid", 64'(rsp_valid), 64'b0010);
    check_vec("col_old_data", 64'(rsp_data), 64'd0);
    tick();
    check_vec("col_new_valid", 64'(rsp_valid), 64'b0010);
    check_vec("col_new_data", 64'(rsp_data), 64'hDEAD_BEEF);
    rd_valid = '0;

    // Write contention, pointer starts just past requester 2
    for (int i = 0; i < N; i++) set_wr(i, 6'(10 + i), 32'h0000_1000 + 32'(i));
    wr_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_vec("rr_wr_ready", 64'(wr_ready), 64'(exp_wr[k]));
      tick();
    end
    wr_valid = '0;
    for (int i = 0; i < N; i++) begin
      set_rd(0, 6'(10 + i));
      rd_valid = 4'b0001;
      tick();
      check_vec("wr_readback", 64'(rsp_data), 64'h1000 + 64'(i));
    end
    rd_valid = '0;

    // Reset with a response on the bus
    set_rd(1, 6'd5);
    rd_valid = 4'b0010;
    tick();
    rd_valid = '0;
    check_vec("flight_pre_valid", 64'(rsp_valid), 64'b0010);
    nreset = 1'b0;
    #1;
    check_vec("flight_rsp_valid", 64'(rsp_valid), 64'd0);
    check_vec("flight_rsp_data", 64'(rsp_data), 64'd0);
    check_vec("flight_init_done", 64'(init_done), 64'd0);
    #12;
    wr_valid = 4'b1111;
    rd_valid = 4'b1111;
    run_init("init2");
    for (int i = 0; i < N; i++) set_rd(i, 6'd5);
    rd_valid = 4'b1111;
    #1;
    check_vec("post_rd_ready", 64'(rd_ready), 64'b0001);
    tick();
    rd_valid = '0;
    check_vec("post_rsp_valid", 64'(rsp_valid), 64'b0001);
    check_vec("post_refill_5", 64'(rsp_data), 64'd0);
    set_rd(0, 6'd10);
    rd_valid = 4'b0001;
    tick();
    rd_valid = '0;
    check_vec("post_refill_10", 64'(rsp_data), 64'd0);
    tick();
    check_vec("post_idle_valid", 64'(rsp_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
